// File: rtl/matmul_sequencer.sv
// Control sequencer for the tiled MxM matrix-multiply engine: walks C tiles, drives A/B reads,
// MAC clear/valid/last and tile write-back. Optional `MM_SEQ_ABORT_EN adds an abort input.
module matmul_sequencer #(
    parameter int N        = 3,
    parameter int M        = 6,
    parameter int RD_LAT   = 1,
    parameter int PIPE_LAT = 2,
    localparam int T       = M / N,
    localparam int AW      = ((M * M) / N) > 1 ? $clog2((M * M) / N) : 1,
    localparam int TW      = (T * T) > 1 ? $clog2(T * T) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr_A,
    output logic [AW-1:0] rd_addr_B,
    output logic          acc_clr,
    output logic          mac_valid,
    output logic          mac_last,
    output logic          wr_en,
    input  logic          wr_ready,
`ifdef MM_SEQ_ABORT_EN
    input  logic          abort,
`endif
    output logic [TW-1:0] wr_addr
);

    localparam int TAW = T > 1 ? $clog2(T) : 1;
    localparam int KW  = M > 1 ? $clog2(M) : 1;
    localparam int DW  = $clog2(RD_LAT + PIPE_LAT + 1);

    localparam logic [KW-1:0]  K_LAST = KW'(M - 1);
    localparam logic [TAW-1:0] T_LAST = TAW'(T - 1);
    localparam logic [DW-1:0]  D_INIT = DW'(RD_LAT + PIPE_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FEED,
        S_DRAIN,
        S_WRITE,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [TAW-1:0]     ta_q, ta_d, tb_q, tb_d;
    logic [KW-1:0]      k_q, k_d;
    logic [DW-1:0]      dcnt_q, dcnt_d;
    logic [AW-1:0]      addr_a_q, addr_a_d, addr_b_q, addr_b_d;
    logic [TW-1:0]      waddr_q, waddr_d;
    logic [RD_LAT-1:0]  vld_q, vld_d, last_q, last_d;
    logic               abort_w;

`ifdef MM_SEQ_ABORT_EN
    assign abort_w = abort;
`else
    assign abort_w = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            ta_q     <= '0;
            tb_q     <= '0;
            k_q      <= '0;
            dcnt_q   <= '0;
            addr_a_q <= '0;
            addr_b_q <= '0;
            waddr_q  <= '0;
            vld_q    <= '0;
            last_q   <= '0;
        end else begin
            state_q  <= state_d;
            ta_q     <= ta_d;
            tb_q     <= tb_d;
            k_q      <= k_d;
            dcnt_q   <= dcnt_d;
            addr_a_q <= addr_a_d;
            addr_b_q <= addr_b_d;
            waddr_q  <= waddr_d;
            vld_q    <= vld_d;
            last_q   <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ta_d    = ta_q;
        tb_d    = tb_q;
        k_d     = k_q;
        dcnt_d  = dcnt_q;
        case (state_q)
            S_IDLE: begin
                if (start && !abort_w) begin
                    state_d = S_CLEAR;
                    ta_d    = '0;
                    tb_d    = '0;
                end
            end
            S_CLEAR: begin
                k_d     = '0;
                state_d = S_FEED;
            end
            S_FEED: begin
                if (k_q == K_LAST) begin
                    state_d = S_DRAIN;
                    dcnt_d  = D_INIT;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            S_DRAIN: begin
                if (dcnt_q == '0) state_d = S_WRITE;
                else              dcnt_d  = dcnt_q - DW'(1);
            end
            S_WRITE: begin
                if (wr_ready) begin
                    if (ta_q == T_LAST && tb_q == T_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_CLEAR;
                        // tb is the fast tile index; wrapping it steps ta
                        if (tb_q == T_LAST) begin
                            tb_d = '0;
                            ta_d = ta_q + TAW'(1);
                        end else begin
                            tb_d = tb_q + TAW'(1);
                        end
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (abort_w && state_q != S_IDLE) begin
            state_d = S_IDLE;
            ta_d    = '0;
            tb_d    = '0;
            k_d     = '0;
            dcnt_d  = '0;
        end

        // Addresses are registered from next-state values so they line up with rd_en/wr_en
        addr_a_d = (state_d == S_FEED) ? AW'(32'(ta_d) * 32'(M) + 32'(k_d)) : '0;
        addr_b_d = (state_d == S_FEED) ? AW'(32'(tb_d) * 32'(M) + 32'(k_d)) : '0;
        waddr_d  = (state_d == S_WRITE) ? TW'(32'(ta_d) * 32'(T) + 32'(tb_d)) : '0;

        vld_d    = '0;
        last_d   = '0;
        vld_d[0]  = (state_q == S_FEED);
        last_d[0] = (state_q == S_FEED) && (k_q == K_LAST);
        for (int i = 1; i < RD_LAT; i++) begin
            vld_d[i]  = vld_q[i-1];
            last_d[i] = last_q[i-1];
        end
        if (abort_w && state_q != S_IDLE) begin
            vld_d  = '0;
            last_d = '0;
        end
    end

    always_comb begin
        busy      = (state_q != S_IDLE);
        done      = (state_q == S_DONE);
        rd_en     = (state_q == S_FEED);
        acc_clr   = (state_q == S_CLEAR);
        wr_en     = (state_q == S_WRITE);
        rd_addr_A = addr_a_q;
        rd_addr_B = addr_b_q;
        wr_addr   = waddr_q;
        mac_valid = vld_q[RD_LAT-1];
        mac_last  = last_q[RD_LAT-1];
    end

endmodule

// File: tb/tb_matmul_sequencer.sv
// Self-checking bench for matmul_sequencer: a per-cycle expected trace is built from the
// tile schedule (clear, M reads, drain, write with stalls, done) and compared every cycle.
module tb_matmul_sequencer;

    localparam int N        = 3;
    localparam int M        = 6;
    localparam int RD_LAT   = 1;
    localparam int PIPE_LAT = 2;
    localparam int T        = M / N;
    localparam int AW       = ((M * M) / N) > 1 ? $clog2((M * M) / N) : 1;
    localparam int TW       = (T * T) > 1 ? $clog2(T * T) : 1;
    localparam int D        = RD_LAT + PIPE_LAT;
    localparam int MAXC     = 256;

    logic          clk;
    logic          rst;
    logic          start;
    logic          busy;
    logic          done;
    logic          rd_en;
    logic [AW-1:0] rd_addr_A;
    logic [AW-1:0] rd_addr_B;
    logic          acc_clr;
    logic          mac_valid;
    logic          mac_last;
    logic          wr_en;
    logic          wr_ready;
    logic [TW-1:0] wr_addr;
`ifdef MM_SEQ_ABORT_EN
    logic          abort;
`endif

    matmul_sequencer #(.N(N), .M(M), .RD_LAT(RD_LAT), .PIPE_LAT(PIPE_LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .rd_en     (rd_en),
        .rd_addr_A (rd_addr_A),
        .rd_addr_B (rd_addr_B),
        .acc_clr   (acc_clr),
        .mac_valid (mac_valid),
        .mac_last  (mac_last),
        .wr_en     (wr_en),
        .wr_ready  (wr_ready),
`ifdef MM_SEQ_ABORT_EN
        .abort     (abort),
`endif
        .wr_addr   (wr_addr)
    );

    typedef struct packed {
        logic          busy;
        logic          done;
        logic          rd_en;
        logic [AW-1:0] a;
        logic [AW-1:0] b;
        logic          acc_clr;
        logic          mac_valid;
        logic          mac_last;
        logic          wr_en;
        logic [TW-1:0] wa;
    } obs_t;

    obs_t exp_tr [MAXC];
    logic rdy_tr [MAXC];
    logic kl_tr  [MAXC];
    int   stall_plan [T*T];
    int   done_cyc;
    int   trace_len;
    int   tests = 0;
    int   fails = 0;
    int   seen;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic obs_t observe();
        obs_t o;
        o.busy      = busy;
        o.done      = done;
        o.rd_en     = rd_en;
        o.a         = rd_addr_A;
        o.b         = rd_addr_B;
        o.acc_clr   = acc_clr;
        o.mac_valid = mac_valid;
        o.mac_last  = mac_last;
        o.wr_en     = wr_en;
        o.wa        = wr_addr;
        return o;
    endfunction

    task automatic check(input string tag, input obs_t o, input obs_t e);
        tests++;
        assert (o === e) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    task automatic check_int(input string tag, input int o, input int e);
        tests++;
        assert (o === e) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
        end
    endtask

    // Expected outputs for cycle c, where cycle 1 follows the edge that samples start.
    task automatic build_trace();
        int c;
        for (int i = 0; i < MAXC; i++) begin
            exp_tr[i] = '0;
            rdy_tr[i] = 1'($urandom_range(0, 1));
            kl_tr[i]  = 1'b0;
        end
        c = 1;
        for (int t = 0; t < T * T; t++) begin
            int ta;
            int tb;
            ta = t / T;
            tb = t % T;
            exp_tr[c].acc_clr = 1'b1;
            c++;
            for (int k = 0; k < M; k++) begin
                exp_tr[c].rd_en = 1'b1;
                exp_tr[c].a     = AW'(ta * M + k);
                exp_tr[c].b     = AW'(tb * M + k);
                kl_tr[c]        = (k == M - 1);
                c++;
            end
            c += D;
            for (int s = 0; s <= stall_plan[t]; s++) begin
                exp_tr[c].wr_en = 1'b1;
                exp_tr[c].wa    = TW'(ta * T + tb);
                rdy_tr[c]       = (s == stall_plan[t]);
                c++;
            end
        end
        exp_tr[c].done = 1'b1;
        done_cyc  = c;
        trace_len = c + 3;
        for (int i = 1; i <= done_cyc; i++) exp_tr[i].busy = 1'b1;
        for (int i = 1 + RD_LAT; i <= trace_len; i++) begin
            exp_tr[i].mac_valid = exp_tr[i-RD_LAT].rd_en;
            exp_tr[i].mac_last  = kl_tr[i-RD_LAT];
        end
    endtask

    // cut_kind: 0 = run to completion, 1 = rst after cycle cut_at, 2 = abort after cycle cut_at
    task automatic run_job(input string name, input int cut_at, input int cut_kind, output int done_seen);
        obs_t zero;
        zero = '0;
        done_seen = -1;
        build_trace();
        start = 1'b1;
        for (int c = 1; c <= trace_len; c++) begin
            @(posedge clk);
            #1;
            start = (c <= done_cyc) ? 1'($urandom_range(0, 1)) : 1'b0;
            check($sformatf("%s_c%0d", name, c), observe(), exp_tr[c]);
            if (done === 1'b1 && done_seen < 0) done_seen = c;
            wr_ready = rdy_tr[c];
            if (c == cut_at) begin
                start = 1'b0;
                if (cut_kind == 1) rst = 1'b1;
`ifdef MM_SEQ_ABORT_EN
                if (cut_kind == 2) abort = 1'b1;
`endif
                @(posedge clk);
                #1;
                rst = 1'b0;
`ifdef MM_SEQ_ABORT_EN
                abort = 1'b0;
`endif
                check($sformatf("%s_cut_next", name), observe(), zero);
                for (int j = 0; j < 4; j++) begin
                    @(posedge clk);
                    #1;
                    check($sformatf("%s_cut_idle%0d", name, j), observe(), zero);
                end
                break;
            end
        end
    endtask

    initial begin
        obs_t zero;
        zero     = '0;
        rst      = 1'b1;
        start    = 1'b0;
        wr_ready = 1'b0;
`ifdef MM_SEQ_ABORT_EN
        abort    = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", observe(), zero);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("idle_after_reset", observe(), zero);

        foreach (stall_plan[t]) stall_plan[t] = 0;
        run_job("nostall", -1, 0, seen);
        check_int("done_at_45", seen, 45);

        foreach (stall_plan[t]) stall_plan[t] = 0;
        stall_plan[1] = 5;
        run_job("stall5", -1, 0, seen);
        check_int("done_at_50", seen, 50);

        foreach (stall_plan[t]) stall_plan[t] = 0;
        run_job("rst_feed2", 26, 1, seen);
        check_int("no_done_after_rst", seen, -1);
        run_job("after_rst", -1, 0, seen);
        check_int("after_rst_done_45", seen, 45);

        for (int r = 0; r < 6; r++) begin
            foreach (stall_plan[t]) stall_plan[t] = int'($urandom_range(0, 4));
            run_job($sformatf("rand%0d", r), -1, 0, seen);
            check_int($sformatf("rand%0d_done", r), seen, done_cyc);
        end

`ifdef MM_SEQ_ABORT_EN
        foreach (stall_plan[t]) stall_plan[t] = 0;
        run_job("abort_drain", 9, 2, seen);
        check_int("no_done_after_abort", seen, -1);
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        check("abort_start_idle0", observe(), zero);
        @(posedge clk);
        #1;
        check("abort_start_idle1", observe(), zero);
        run_job("after_abort", -1, 0, seen);
        check_int("after_abort_done_45", seen, 45);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
